// File: rtl/ika2151_pkg.sv
// Shared widths, terminal counts and helpers for the IKA2151 Timer A / Timer B block.
package ika2151_pkg;

    localparam int TA_W          = 10;
    localparam int TB_W          = 8;
    localparam int TB_PRESCALE_W = 4;

    localparam logic [TA_W-1:0] TA_MAX = 10'h3FF;
    localparam logic [TB_W-1:0] TB_MAX = 8'hFF;

    typedef enum logic [1:0] {
        CNT_IDLE  = 2'd0,
        CNT_LOAD  = 2'd1,
        CNT_COUNT = 2'd2
    } cnt_mode_e;

    // A set request on the same edge as a clear request wins.
    function automatic logic next_flag(input logic flag, input logic set, input logic clr);
        logic nxt;
        if (set) begin
            nxt = 1'b1;
        end else if (clr) begin
            nxt = 1'b0;
        end else begin
            nxt = flag;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ika2151_timer_cntr.sv
// Up-counter with idle/load/count phases; reloads on terminal count and flags the overflow.
module ika2151_timer_cntr
    import ika2151_pkg::*;
#(
    parameter int          W   = 10,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         step_en,
    input  logic         load,
    input  logic [W-1:0] reload_val,
    output logic         ovf,
    output logic         counting
);

    logic [W-1:0] cnt;
    logic         load_d;
    cnt_mode_e    mode;

    // Phase decode: a rising LOAD (relative to the previous tick) is a fresh load.
    always_comb begin
        if (!load) begin
            mode = CNT_IDLE;
        end else if (!load_d) begin
            mode = CNT_LOAD;
        end else begin
            mode = CNT_COUNT;
        end
    end

    assign counting = (mode == CNT_COUNT);
    assign ovf      = tick && step_en && counting && (cnt == MAX);

    // Counter and load history advance only on ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= {W{1'b0}};
            load_d <= 1'b0;
        end else if (tick) begin
            load_d <= load;
            case (mode)
                CNT_IDLE:  cnt <= cnt;
                CNT_LOAD:  cnt <= reload_val;
                CNT_COUNT: begin
                    if (step_en) begin
                        cnt <= (cnt == MAX) ? reload_val : cnt + {{(W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt <= cnt;
                    end
                end
                default:   cnt <= cnt;
            endcase
        end else begin
            cnt    <= cnt;
            load_d <= load_d;
        end
    end

endmodule

// File: rtl/ika2151_timer.sv
// IKA2151 Timer A (10-bit) and Timer B (8-bit, /16 prescaled) with status flags, IRQ and CSM.
module ika2151_timer
    import ika2151_pkg::*;
#(
    parameter int TA_W          = ika2151_pkg::TA_W,
    parameter int TB_W          = ika2151_pkg::TB_W,
    parameter int TB_PRESCALE_W = ika2151_pkg::TB_PRESCALE_W
) (
    input  logic            i_EMUCLK,
    input  logic            i_RST,
    input  logic            i_phi1_NCEN_n,
    input  logic            i_CYCLE_31,
    input  logic [TA_W-1:0] i_TA_VAL,
    input  logic [TB_W-1:0] i_TB_VAL,
    input  logic            i_LOAD_A,
    input  logic            i_LOAD_B,
    input  logic            i_IRQEN_A,
    input  logic            i_IRQEN_B,
    input  logic            i_FRST_A,
    input  logic            i_FRST_B,
    output logic            o_TA_FLAG,
    output logic            o_TB_FLAG,
    output logic            o_IRQ_n,
    output logic            o_CSM
);

    logic                     en;
    logic                     tick;
    logic                     ovf_a;
    logic                     ovf_b;
    logic                     counting_a;
    logic                     counting_b;
    logic                     step_b;
    logic [TB_PRESCALE_W-1:0] prescale;
    logic                     ta_flag;
    logic                     tb_flag;
    logic                     irq_n;
    logic                     csm;

    assign en     = ~i_phi1_NCEN_n;
    assign tick   = en & i_CYCLE_31;
    assign step_b = (prescale == {TB_PRESCALE_W{1'b1}});

    ika2151_timer_cntr #(.W(TA_W), .MAX(TA_MAX)) u_cntr_a (
        .clk        (i_EMUCLK),
        .rst        (i_RST),
        .tick       (tick),
        .step_en    (1'b1),
        .load       (i_LOAD_A),
        .reload_val (i_TA_VAL),
        .ovf        (ovf_a),
        .counting   (counting_a)
    );

    ika2151_timer_cntr #(.W(TB_W), .MAX(TB_MAX)) u_cntr_b (
        .clk        (i_EMUCLK),
        .rst        (i_RST),
        .tick       (tick),
        .step_en    (step_b),
        .load       (i_LOAD_B),
        .reload_val (i_TB_VAL),
        .ovf        (ovf_b),
        .counting   (counting_b)
    );

    // Timer B prescaler: runs only while Timer B is counting, cleared on idle and load ticks.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            prescale <= {TB_PRESCALE_W{1'b0}};
        end else if (tick) begin
            prescale <= counting_b ? prescale + {{(TB_PRESCALE_W-1){1'b0}}, 1'b1}
                                   : {TB_PRESCALE_W{1'b0}};
        end else begin
            prescale <= prescale;
        end
    end

    // Flags, IRQ and CSM; IRQ lags the flags by one enabled edge.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            ta_flag <= 1'b0;
            tb_flag <= 1'b0;
            irq_n   <= 1'b1;
            csm     <= 1'b0;
        end else if (en) begin
            ta_flag <= next_flag(ta_flag, ovf_a & i_IRQEN_A, i_FRST_A);
            tb_flag <= next_flag(tb_flag, ovf_b & i_IRQEN_B, i_FRST_B);
            irq_n   <= ~(ta_flag | tb_flag);
            csm     <= ovf_a;
        end else begin
            ta_flag <= ta_flag;
            tb_flag <= tb_flag;
            irq_n   <= irq_n;
            csm     <= csm;
        end
    end

    assign o_TA_FLAG = ta_flag;
    assign o_TB_FLAG = tb_flag;
    assign o_IRQ_n   = irq_n;
    assign o_CSM     = csm;

endmodule

// File: tb/tb_ika2151_timer.sv
// Directed bench for ika2151_timer: a vector table for reset/Timer A, hand sequences for the rest.
module tb_ika2151_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ncen_n = 1'b1;
    logic       cyc31 = 1'b0;
    logic [9:0] ta_val = 10'd0;
    logic [7:0] tb_val = 8'd0;
    logic       load_a = 1'b0, load_b = 1'b0;
    logic       irqen_a = 1'b0, irqen_b = 1'b0;
    logic       frst_a = 1'b0, frst_b = 1'b0;
    logic       ta_flag, tb_flag, irq_n, csm;

    int pass_cnt = 0;
    int total_cnt = 0;

    ika2151_timer dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen_n),
        .i_CYCLE_31    (cyc31),
        .i_TA_VAL      (ta_val),
        .i_TB_VAL      (tb_val),
        .i_LOAD_A      (load_a),
        .i_LOAD_B      (load_b),
        .i_IRQEN_A     (irqen_a),
        .i_IRQEN_B     (irqen_b),
        .i_FRST_A      (frst_a),
        .i_FRST_B      (frst_b),
        .o_TA_FLAG     (ta_flag),
        .o_TB_FLAG     (tb_flag),
        .o_IRQ_n       (irq_n),
        .o_CSM         (csm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       c31;
        logic       load_a;
        logic       irqen_a;
        logic       frst_a;
        logic [9:0] ta;
        logic [3:0] exp;   // {TA_FLAG, TB_FLAG, IRQ_n, CSM}
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic e, input logic c, input logic la,
                                input logic ie, input logic fr, input logic [9:0] t,
                                input logic [3:0] x);
        vec_t v;
        v.rst = r; v.en = e; v.c31 = c; v.load_a = la;
        v.irqen_a = ie; v.frst_a = fr; v.ta = t; v.exp = x;
        return v;
    endfunction

    task automatic step(input logic en, input logic c31);
        @(negedge clk);
        ncen_n = ~en;
        cyc31  = c31;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [3:0] exp);
        total_cnt++;
        if ({ta_flag, tb_flag, irq_n, csm} === exp) pass_cnt++;
        else $display("FAIL %s: got {ta,tb,irq_n,csm}=%b expected %b", name, {ta_flag, tb_flag, irq_n, csm}, exp);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset, reset mid-count, 4-tick overflow, disabled strobes, clear latency
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    4'b0010);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);
        vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b1011);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b1000);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1020, 4'b0000);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1020, 4'b0010);

        for (int i = 0; i < 18; i++) begin
            rst     = vecs[i].rst;
            load_a  = vecs[i].load_a;
            irqen_a = vecs[i].irqen_a;
            frst_a  = vecs[i].frst_a;
            ta_val  = vecs[i].ta;
            step(vecs[i].en, vecs[i].c31);
            check_all($sformatf("vec%0d", i), vecs[i].exp);
        end
        frst_a = 1'b0;

        // Timer A period of one tick, set-wins, flag persistence
        do_reset();
        ta_val = 10'd1023; load_a = 1'b1; irqen_a = 1'b1;
        step(1'b1, 1'b1);
        check_all("a1023_load", 4'b0010);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            chk1($sformatf("a1023_csm%0d", i), csm, 1'b1);
            chk1($sformatf("a1023_flag%0d", i), ta_flag, 1'b1);
        end
        step(1'b1, 1'b0);
        chk1("a1023_csm_clr", csm, 1'b0);
        chk1("a1023_irq", irq_n, 1'b0);
        frst_a = 1'b1;
        step(1'b1, 1'b1);
        chk1("set_wins", ta_flag, 1'b1);
        frst_a = 1'b0;
        load_a = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk1("flag_persist", ta_flag, 1'b1);
        chk1("idle_no_csm", csm, 1'b0);
        frst_a = 1'b1;
        step(1'b1, 1'b0);
        frst_a = 1'b0;
        chk1("a_flag_clr", ta_flag, 1'b0);

        // Timer B prescale: 32-tick period with TB_VAL=254
        do_reset();
        irqen_a = 1'b0;
        tb_val = 8'd254; load_b = 1'b1; irqen_b = 1'b1;
        step(1'b1, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 1'b1);
            if (k == 31) chk1("b_p1_early", tb_flag, 1'b0);
            if (k == 32) begin
                chk1("b_p1_flag", tb_flag, 1'b1);
                chk1("b_p1_irq_lag", irq_n, 1'b1);
            end
        end
        step(1'b1, 1'b0);
        chk1("b_irq_fall", irq_n, 1'b0);
        frst_b = 1'b1;
        step(1'b1, 1'b0);
        frst_b = 1'b0;
        chk1("b_flag_clr", tb_flag, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 1'b1);
            if (k == 31) chk1("b_p2_early", tb_flag, 1'b0);
            if (k == 32) chk1("b_p2_flag", tb_flag, 1'b1);
        end

        // IRQEN gating: overflow at 24 ticks, CSM only
        do_reset();
        load_b = 1'b0; irqen_b = 1'b0;
        ta_val = 10'd1000; load_a = 1'b1; irqen_a = 1'b0;
        step(1'b1, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'b1);
            if (k == 23) chk1("gate_early", csm, 1'b0);
            if (k == 24) check_all("gate_ovf", 4'b0011);
        end
        step(1'b1, 1'b0);
        check_all("gate_after", 4'b0010);

        // Freeze and reload
        do_reset();
        ta_val = 10'd0; load_a = 1'b1; irqen_a = 1'b1;
        step(1'b1, 1'b1);
        repeat (100) step(1'b1, 1'b1);
        load_a = 1'b0;
        repeat (50) step(1'b1, 1'b1);
        chk1("freeze_noflag", ta_flag, 1'b0);
        ta_val = 10'd1014; load_a = 1'b1;
        step(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1);
            if (k == 9) chk1("reload_early", csm, 1'b0);
            if (k == 10) begin
                chk1("reload_csm", csm, 1'b1);
                chk1("reload_flag", ta_flag, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ika2151_timer.md
# ika2151_timer

Timer A / Timer B block of the IKA2151 core, directly downstream of the timing generator. It consumes the phi1 negative-edge clock enable and the once-per-sample cycle strobe, runs the 10-bit Timer A and the 8-bit Timer B (÷16 prescaled), and drives the status flags, the active-low IRQ and the CSM key-on pulse. Register values and control bits come from the register file.

## Interface
Parameters:
- `TA_W`, default 10: Timer A counter width.
- `TB_W`, default 8: Timer B counter width.
- `TB_PRESCALE_W`, default 4: Timer B prescaler width (÷16).

Ports:
- `i_EMUCLK`, input, 1: emulator master clock. This is the only clock.
- `i_RST`, input, 1: reset, synchronous and active-high.
- `i_phi1_NCEN_n`, input, 1: phi1 negative-edge clock enable, active low.
- `i_CYCLE_31`, input, 1: sample strobe from the timing generator, high for one phi1 cycle out of every 32.
- `i_TA_VAL`, input, 10: Timer A reload value.
- `i_TB_VAL`, input, 8: Timer B reload value.
- `i_LOAD_A`, `i_LOAD_B`, input, 1 each: timer run/load bits.
- `i_IRQEN_A`, `i_IRQEN_B`, input, 1 each: flag-set enables.
- `i_FRST_A`, `i_FRST_B`, input, 1 each: flag clear requests, honoured on any enabled edge.
- `o_TA_FLAG`, `o_TB_FLAG`, output, 1 each: timer status flags.
- `o_IRQ_n`, output, 1: active-low interrupt.
- `o_CSM`, output, 1: CSM key-on pulse, asserted on Timer A overflow.

## Operation
- **Enabled edge:** a rising edge of `i_EMUCLK` with `i_phi1_NCEN_n=0`.
- **Tick:** an enabled edge with `i_CYCLE_31=1`. Counters, prescaler and load history change only on ticks.
- **Reset** (`i_RST=1` on any `i_EMUCLK` edge, regardless of enables):
  - counters, prescaler and `load_d` registers go to 0
  - `o_TA_FLAG=0`, `o_TB_FLAG=0`, `o_CSM=0`, `o_IRQ_n=1`
  - reset overrides every other input
- **Timer A, per tick:**
  - **Idle** (LOAD_A=0): counter holds; no overflow.
  - **Load** (LOAD_A=1, load_d_A=0): `cnt_A <= TA_VAL`.
  - **Count** (LOAD_A=1, load_d_A=1):
    - If `cnt_A==1023`: overflow; `cnt_A <= TA_VAL`.
    - Otherwise `cnt_A <= cnt_A+1`.
  - `load_d_A <= LOAD_A` on every tick.
  - Overflow period is 1024−TA_VAL ticks.
- **Timer B, per tick:** same idle/load/count structure, with these differences:
  - The prescaler clears on Idle and on Load.
  - In Count, the prescaler increments, and `cnt_B` steps only when the prescaler wraps 15→0.
  - Overflow occurs when `cnt_B==255` on a step.
  - Overflow period is 16·(256−TB_VAL) ticks.
- **Flags:**
  - An overflow with its IRQEN=1 sets the flag.
  - FRST clears the flag.
  - If set and clear occur on the same edge, **set wins**.
  - A flag persists while LOAD is deasserted.
- **IRQ:** `o_IRQ_n` is registered and equals ~(TA_FLAG | TB_FLAG), updated on enabled edges.
- **CSM:**
  - Asserted for exactly one phi1 cycle on Timer A overflow, independent of IRQEN_A.
  - Cleared on the next enabled edge.
- **TA_VAL / TB_VAL changes** take effect only at the next Load or overflow reload.
- **Mid-count LOAD deassert:** the counter freezes. Re-assertion is a new Load, so the counter reloads.

## Timing
- All outputs are registered.
- Flag and `o_CSM` are visible on the tick edge that overflows.
- `o_IRQ_n` follows one enabled edge after the flag.
- Flag clear latency is 1 enabled edge; `o_IRQ_n` deasserts on the following enabled edge.
- Ticks without `i_phi1_NCEN_n=0` do not exist; `i_CYCLE_31` sampled on non-enabled edges is ignored.

## Structure
- **Package** `ika2151_pkg` holds:
  - the widths `TA_W`, `TB_W`, `TB_PRESCALE_W`
  - the constants `TA_MAX=10'h3FF`, `TB_MAX=8'hFF`
- **Sub-module** `ika2151_timer_cntr` (parameter `W`) is instantiated twice.
  - Inputs: tick, step enable, load, reload value.
  - Internal: the `load_d` state.
  - Outputs: the overflow strobe.
- The Timer B prescaler, the flags, IRQ and CSM live in the top module.

## Test plan
- **Reset:** hold `i_RST` for 3 enabled edges mid-count → both flags 0, `o_IRQ_n=1`, `o_CSM=0`. Then LOAD_A=1 with TA_VAL=1020 → overflow exactly 4 ticks after the load tick.
- **Timer A period:** TA_VAL=1023, LOAD_A=1, IRQEN_A=1 → `o_CSM` pulses every tick after load. Assert FRST_A on an overflow tick → TA_FLAG stays 1 (set wins).
- **Timer B prescale:** TB_VAL=254, LOAD_B=1, IRQEN_B=1 → TB_FLAG sets 32 ticks after the load tick, then every 32 ticks. `o_IRQ_n` falls one enabled edge after TB_FLAG.
- **IRQEN gating:** IRQEN_A=0, TA_VAL=1000 → overflow at 24 ticks, `o_CSM` pulses, TA_FLAG stays 0, `o_IRQ_n` stays 1.
- **Freeze / reload:** with TA_VAL=0, deassert LOAD_A after 100 ticks for 50 ticks, then reassert with TA_VAL=1014 → counter reloads, and the next overflow comes 10 ticks after the reassert tick.
- **Strobe gating:** `i_CYCLE_31` high on edges where `i_phi1_NCEN_n=1` → no counter movement.
